vga_data_check: RTL
===================

VGA_DATA_CHECK -- requirements
Module: vga_data_check

Interface
REQ-001 Parameter DATA_DEPTH, default 1024*768, words per frame (1..2^20).
REQ-002 Parameter SPAN_NUM, default 1, start-value increment per completed frame.
REQ-003 clk  input  1  clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  start toggle from another clock domain; either edge starts a frame check.
REQ-006 rd_req  output  1  checker requests readback data this cycle.
REQ-007 din_valid  input  1  din holds one readback word this cycle.
REQ-008 din  input  16  readback pixel word.
REQ-009 busy  output  1  frame check in progress.
REQ-010 done  output  1  one-cycle pulse when a frame check finishes.
REQ-011 pass  output  1  result of the last finished frame: 1 = no mismatches.
REQ-012 err_cnt  output  16  mismatch count of the current or last frame, saturating.
REQ-013 first_err_addr  output  20  word index of the first mismatch in the current or last frame.

Function
REQ-014 start_i SHALL pass through a 3-flop chain; start_pulse = stage2 XOR stage3, so checking begins 3-4 cycles after a toggle.
REQ-015 FSM states: IDLE, PRE_READ, READING, COMPLETE. IDLE->PRE_READ on start_pulse; PRE_READ->READING unconditionally; READING->COMPLETE on the edge that accepts word DATA_DEPTH-1; COMPLETE->IDLE unconditionally.
REQ-016 start_pulse outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-017 PRE_READ SHALL set expected index = pixel_init (10-bit) and word count = 0, and SHALL clear err_cnt, first_err_addr and the first-error flag.
REQ-018 rd_req = 1 exactly while the state is READING; busy = 1 in PRE_READ, READING and COMPLETE.
REQ-019 A word is accepted when READING and din_valid = 1. Acceptance increments word count and expected index; expected index wraps modulo 1024.
REQ-020 Expected word = {6'd0, expected[9:0]}. Any bit difference, including nonzero din[15:10], is a mismatch.
REQ-021 A mismatch SHALL increment err_cnt on the accepting edge, saturating at 16'hFFFF.
REQ-022 The first mismatch of a frame SHALL load first_err_addr with its word count; later mismatches SHALL NOT change it.
REQ-023 din_valid outside READING SHALL be ignored: no count, no compare.
REQ-024 In COMPLETE, pixel_init <= (pixel_init + SPAN_NUM) mod 1024.
REQ-025 done SHALL be registered high for exactly the one cycle following the COMPLETE cycle (two edges after the last accepted word). pass SHALL update on that same edge to (err_cnt == 0).
REQ-026 err_cnt, first_err_addr and pass SHALL hold until the next PRE_READ.
REQ-027 The frame ends on accepted-word count only. Gaps in din_valid SHALL stall the check without timeout.

Reset
REQ-028 Asserting rst_n low SHALL asynchronously force:
- state to IDLE
- sync flops, pixel_init, expected index and word count to 0
- rd_req, busy, done, pass to 0
- err_cnt and first_err_addr to 0
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; the next frame SHALL expect words starting at 0.

Verification (DATA_DEPTH=8 unless stated)
REQ-030 Reset -> all outputs 0, rd_req 0; a single start_i toggle -> rd_req rises 4-5 cycles later.
REQ-031 Frame 1, din = 0..7 with valid gaps -> single done pulse, pass=1, err_cnt=0. Frame 2, din = 1..8 -> pass=1.
REQ-032 Frame with words 3 and 5 corrupted (word 5 = 16'h0405) -> err_cnt=2, first_err_addr=3, pass=0.
REQ-033 SPAN_NUM=1020, frame 2 expects 1020,1021,1022,1023,0,1,2,3 -> pass=1; feeding 1024 at index 4 -> err_cnt=1, first_err_addr=4.
REQ-034 start_i toggled during READING -> no restart and exactly one done. rst_n pulsed after word 4 -> rd_req 0, no done; next frame expects 0..7.
REQ-035 DATA_DEPTH=70000, all words wrong -> err_cnt saturates at 16'hFFFF, first_err_addr=0, pass=0.

Source files
------------

// File: rtl/vga_data_check.sv
// Frame readback checker: compares each accepted word against an incrementing
// 10-bit pixel index and reports mismatch count, first error position and pass/fail.
module vga_data_check #(
    parameter int DATA_DEPTH = 1024*768,
    parameter int SPAN_NUM   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        rd_req,
    input  logic        din_valid,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [19:0] first_err_addr
);

    localparam logic [19:0] LAST_WORD = 20'(DATA_DEPTH - 1);
    localparam logic [9:0]  SPAN_STEP = 10'(SPAN_NUM);

    typedef enum logic [1:0] {
        IDLE,
        PRE_READ,
        READING,
        COMPLETE
    } state_t;

    state_t      state;
    logic [2:0]  start_sync;
    logic        start_pulse;
    logic [9:0]  pixel_init;
    logic [9:0]  expected;
    logic [19:0] word_cnt;
    logic        first_seen;
    logic        accept;
    logic        mismatch;

    // start_i toggles in a foreign domain; any edge of the synchronised level is a request
    assign start_pulse = start_sync[1] ^ start_sync[2];
    assign accept      = (state == READING) && din_valid;
    assign mismatch    = din != {6'd0, expected};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= 3'b000;
        end else begin
            start_sync <= {start_sync[1:0], start_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pixel_init     <= 10'd0;
            expected       <= 10'd0;
            word_cnt       <= 20'd0;
            first_seen     <= 1'b0;
            rd_req         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= 20'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state <= PRE_READ;
                        busy  <= 1'b1;
                    end
                end
                PRE_READ: begin
                    expected       <= pixel_init;
                    word_cnt       <= 20'd0;
                    err_cnt        <= 16'd0;
                    first_err_addr <= 20'd0;
                    first_seen     <= 1'b0;
                    pass           <= 1'b0;
                    rd_req         <= 1'b1;
                    state          <= READING;
                end
                READING: begin
                    if (accept) begin
                        word_cnt <= word_cnt + 20'd1;
                        expected <= expected + 10'd1;
                        if (mismatch) begin
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                            if (!first_seen) begin
                                first_seen     <= 1'b1;
                                first_err_addr <= word_cnt;
                            end
                        end
                        // Frame length is counted in accepted words; din_valid gaps just stall
                        if (word_cnt == LAST_WORD) begin
                            rd_req <= 1'b0;
                            state  <= COMPLETE;
                        end
                    end
                end
                COMPLETE: begin
                    pixel_init <= pixel_init + SPAN_STEP;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    pass       <= (err_cnt == 16'd0);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
